// File: rtl/if_stage.sv
// if_stage: RV32 instruction fetch stage with PC register, imem request and IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt/flush_cnt performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_cpu,
    input  logic        rst_cpu,
    input  logic        stall_if,
    input  logic        flush,
    input  logic        pc_sel,
    input  logic        npc_sel,
    input  logic [31:0] pc_imm_ex,
    input  logic [31:0] res_ex,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] pc_id,
    output logic [31:0] inst_id,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        valid_id
);
    logic        redirect;
    logic        fire;
    logic [31:0] target;
    logic [31:0] pc_next;
    always_comb begin
        redirect  = pc_sel | npc_sel;
        target    = npc_sel ? pc_imm_ex : {res_ex[31:1], 1'b0};
        imem_req  = ~rst_cpu & ~stall_if;
        fire      = imem_req & imem_ready;
        imem_addr = pc_if;
        pc_next   = redirect ? target : fire ? pc_if + 32'd4 : pc_if;
    end
    always_ff @(posedge clk_cpu) begin
        pc_if <= rst_cpu ? RESET_PC : pc_next;
    end
    // Flush beats stall so a redirect never leaves a stale instruction in decode.
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu || flush) begin
            pc_id    <= 32'd0;
            inst_id  <= NOP_INST;
            valid_id <= 1'b0;
        end else if (!stall_if) begin
            pc_id    <= fire ? pc_if : pc_id;
            inst_id  <= fire ? imem_rdata : NOP_INST;
            valid_id <= fire;
        end
    end
`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            fetch_cnt <= fetch_cnt + {31'd0, fire & ~redirect};
            flush_cnt <= flush_cnt + {31'd0, flush};
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
module tb_if_stage;
    logic        clk_cpu = 1'b0;
    logic        rst_cpu = 1'b1;
    logic        stall_if = 1'b0;
    logic        flush = 1'b0;
    logic        pc_sel = 1'b0;
    logic        npc_sel = 1'b0;
    logic [31:0] pc_imm_ex = 32'd0;
    logic [31:0] res_ex = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    if_stage dut (
        .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .stall_if(stall_if), .flush(flush),
        .pc_sel(pc_sel), .npc_sel(npc_sel), .pc_imm_ex(pc_imm_ex), .res_ex(res_ex),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc_if(pc_if), .pc_id(pc_id), .inst_id(inst_id),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
        .valid_id(valid_id)
    );

    always #5 clk_cpu = ~clk_cpu;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] pid,
                          input logic [31:0] inst, input logic v);
        chk({tag, ".pc_if"}, pc_if, pc);
        chk({tag, ".pc_id"}, pc_id, pid);
        chk({tag, ".inst_id"}, inst_id, inst);
        chk({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, v});
    endtask

    task automatic redirect_to(input logic [31:0] t);
        flush = 1'b1; npc_sel = 1'b1; pc_imm_ex = t;
        step();
        flush = 1'b0; npc_sel = 1'b0;
    endtask

    initial begin
        step();
        chk_id("reset", 32'h0, 32'h0, 32'h13, 1'b0);
        chk("reset.imem_req", {31'd0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("reset.fetch_cnt", fetch_cnt, 32'd0);
        chk("reset.flush_cnt", flush_cnt, 32'd0);
`endif
        rst_cpu = 1'b0; imem_ready = 1'b1;
        #1;
        chk("run.imem_req", {31'd0, imem_req}, 32'd1);
        chk("run.imem_addr0", imem_addr, 32'h0);
        step(); chk_id("seq1", 32'h4, 32'h0, mem(32'h0), 1'b1);
        chk("seq1.imem_addr", imem_addr, 32'h4);
        step(); chk_id("seq2", 32'h8, 32'h4, mem(32'h4), 1'b1);
        step(); chk_id("seq3", 32'hC, 32'h8, mem(32'h8), 1'b1);
        chk("seq3.imem_addr", imem_addr, 32'hC);
        step(); chk_id("seq4", 32'h10, 32'hC, mem(32'hC), 1'b1);
        stall_if = 1'b1;
        #1;
        chk("stall.imem_req", {31'd0, imem_req}, 32'd0);
        step(); chk_id("stall1", 32'h10, 32'hC, mem(32'hC), 1'b1);
        step(); chk_id("stall2", 32'h10, 32'hC, mem(32'hC), 1'b1);
        stall_if = 1'b0;
        step(); chk_id("unstall", 32'h14, 32'h10, mem(32'h10), 1'b1);
        step(); step(); step();
        chk_id("at20", 32'h20, 32'h1C, mem(32'h1C), 1'b1);
        redirect_to(32'h100);
        chk_id("br", 32'h100, 32'h0, 32'h13, 1'b0);
        step(); chk_id("br_tgt", 32'h104, 32'h100, mem(32'h100), 1'b1);
        flush = 1'b1; pc_sel = 1'b1; res_ex = 32'h0000_0203; stall_if = 1'b1;
        step();
        flush = 1'b0; pc_sel = 1'b0; stall_if = 1'b0;
        chk_id("jalr", 32'h202, 32'h0, 32'h13, 1'b0);
        step(); chk_id("jalr_tgt", 32'h206, 32'h202, mem(32'h202), 1'b1);
        redirect_to(32'h40);
        imem_ready = 1'b0;
        step(); chk_id("nrdy1", 32'h40, 32'h0, 32'h13, 1'b0);
        step(); chk_id("nrdy2", 32'h40, 32'h0, 32'h13, 1'b0);
        step(); chk_id("nrdy3", 32'h40, 32'h0, 32'h13, 1'b0);
        imem_ready = 1'b1;
        step(); chk_id("rdy", 32'h44, 32'h40, mem(32'h40), 1'b1);
        step(); chk_id("rdy2", 32'h48, 32'h44, mem(32'h44), 1'b1);
        redirect_to(32'hFFFF_FFFC);
        chk("wrap.pre", pc_if, 32'hFFFF_FFFC);
        step(); chk_id("wrap", 32'h0, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1);
        step(); chk("wrap.next", pc_if, 32'h4);
`ifdef IF_PERF_CNT_EN
        chk("run.flush_cnt", flush_cnt, 32'd4);
`endif
        stall_if = 1'b1; npc_sel = 1'b1; flush = 1'b1; pc_imm_ex = 32'h80; rst_cpu = 1'b1;
        step();
        chk_id("midrst", 32'h0, 32'h0, 32'h13, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("midrst.fetch_cnt", fetch_cnt, 32'd0);
        chk("midrst.flush_cnt", flush_cnt, 32'd0);
`endif
        stall_if = 1'b0; npc_sel = 1'b0; flush = 1'b0; rst_cpu = 1'b0;
        step(); chk_id("post_rst", 32'h4, 32'h0, mem(32'h0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
